// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - shared types, flag indices and bias helper for fp_mult_pipe
// Stage records depend on the instance widths, so they are declared inside the top.
package fp_mult_pkg;

  typedef enum logic {
    RNE = 1'b0,
    RTZ = 1'b1
  } rnd_mode_e;

  localparam int FLG_OVF = 2;
  localparam int FLG_UDF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_round.sv
// rtl/fp_mult_pipe_round.sv - normalise, guard/sticky, RNE/RTZ rounding, carry renormalise
// Purely combinational; used by the second pipeline stage.
module fp_round
  import fp_mult_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic [2*FRAC_W+1:0] prod,
  input  logic [EXP_W+1:0]    exp_in,
  input  rnd_mode_e           rnd,
  output logic [FRAC_W-1:0]   frac,
  output logic [EXP_W+1:0]    exp_out,
  output logic                inexact
);

  localparam int PW = 2*FRAC_W + 2;
  localparam int XW = EXP_W + 2;

  logic [PW-1:0]     norm;
  logic [XW-1:0]     exp_n;
  logic [FRAC_W:0]   mant;
  logic              guard;
  logic              sticky;
  logic              up;
  logic [FRAC_W+1:0] sum;

  always_comb begin
    // Leading one sits in one of the top two bits; align it to the MSB.
    norm    = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
    exp_n   = exp_in + XW'(prod[PW-1]);
    mant    = norm[PW-1:PW-1-FRAC_W];
    guard   = norm[PW-2-FRAC_W];
    sticky  = |norm[PW-3-FRAC_W:0];
    up      = (rnd == RNE) && guard && (sticky || mant[0]);
    sum     = {1'b0, mant} + (FRAC_W+2)'(up);
    frac    = sum[FRAC_W+1] ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
    exp_out = exp_n + XW'(sum[FRAC_W+1]);
    inexact = guard || sticky;
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - 3-stage floating-point multiplier with valid/ready backpressure
// Optional special-value handling (zero/Inf/NaN, Inf on RNE overflow) under FPMUL_SPECIAL_EN.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     in_a,
  input  logic [EXP_W+FRAC_W:0]     in_b,
  input  logic                      in_rnd,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_p,
  output logic [TAG_W-1:0]          out_tag,
  output logic [2:0]                out_flags
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int PW = 2*FRAC_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0]        BIAS = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             sign;
    logic [XW-1:0]    exp;
    logic [PW-1:0]    prod;
    rnd_mode_e        rnd;
    logic [TAG_W-1:0] tag;
`ifdef FPMUL_SPECIAL_EN
    logic             spec;
    logic [W-1:0]     spec_word;
`endif
  } s12_t;

  typedef struct packed {
    logic              sign;
    logic [XW-1:0]     exp;
    logic [FRAC_W-1:0] frac;
    logic              inexact;
    logic [TAG_W-1:0]  tag;
`ifdef FPMUL_SPECIAL_EN
    rnd_mode_e         rnd;
    logic              spec;
    logic [W-1:0]      spec_word;
`endif
  } s23_t;

  logic v1, v2, v3;
  logic adv2, adv3;
  s12_t s1_q, s1_d;
  s23_t s2_q, s2_d;
  logic [W-1:0] p_word;
  logic [2:0]   p_flags;
  logic [FRAC_W-1:0] r_frac;
  logic [XW-1:0]     r_exp;
  logic              r_inx;

  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v3;

  // Stage 1: unpack and multiply significands.
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  assign ea = in_a[W-2:FRAC_W];
  assign eb = in_b[W-2:FRAC_W];
  assign fa = in_a[FRAC_W-1:0];
  assign fb = in_b[FRAC_W-1:0];

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_a[W-1] ^ in_b[W-1];
    s1_d.exp  = XW'(ea) + XW'(eb) - BIAS;
    s1_d.prod = PW'({1'b1, fa}) * PW'({1'b1, fb});
    s1_d.rnd  = rnd_mode_e'(in_rnd);
    s1_d.tag  = in_tag;
`ifdef FPMUL_SPECIAL_EN
    begin
      logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == '1) && (fa == '0);
      b_inf  = (eb == '1) && (fb == '0);
      a_nan  = (ea == '1) && (fa != '0);
      b_nan  = (eb == '1) && (fb != '0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
        s1_d.spec      = 1'b1;
        s1_d.spec_word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      end else if (a_inf || b_inf) begin
        s1_d.spec      = 1'b1;
        s1_d.spec_word = {s1_d.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (a_zero || b_zero) begin
        s1_d.spec      = 1'b1;
        s1_d.spec_word = {s1_d.sign, {(W-1){1'b0}}};
      end
    end
`endif
  end

  // Stage 2: normalise and round.
  fp_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
    .prod    (s1_q.prod),
    .exp_in  (s1_q.exp),
    .rnd     (s1_q.rnd),
    .frac    (r_frac),
    .exp_out (r_exp),
    .inexact (r_inx)
  );

  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.exp     = r_exp;
    s2_d.frac    = r_frac;
    s2_d.inexact = r_inx;
    s2_d.tag     = s1_q.tag;
`ifdef FPMUL_SPECIAL_EN
    s2_d.rnd       = s1_q.rnd;
    s2_d.spec      = s1_q.spec;
    s2_d.spec_word = s1_q.spec_word;
`endif
  end

  // Stage 3: clamp and pack; no subnormals are produced.
  always_comb begin
    p_word           = {s2_q.sign, s2_q.exp[EXP_W-1:0], s2_q.frac};
    p_flags          = '0;
    p_flags[FLG_INX] = s2_q.inexact;
    if ($signed(s2_q.exp) >= EMAX) begin
      p_flags[FLG_OVF] = 1'b1;
      p_flags[FLG_INX] = 1'b1;
      p_word = {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
`ifdef FPMUL_SPECIAL_EN
      if (s2_q.rnd == RNE)
        p_word = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`endif
    end else if ($signed(s2_q.exp) <= 0) begin
      p_flags[FLG_UDF] = 1'b1;
      p_flags[FLG_INX] = 1'b1;
      p_word = {s2_q.sign, {(W-1){1'b0}}};
    end
`ifdef FPMUL_SPECIAL_EN
    if (s2_q.spec) begin
      p_word  = s2_q.spec_word;
      p_flags = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_p     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else begin
      if (in_ready) begin
        v1 <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) s2_q <= s2_d;
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          out_p     <= p_word;
          out_tag   <= s2_q.tag;
          out_flags <= p_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - directed self-checking bench for fp_mult_pipe (binary16 defaults)
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        in_rnd;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [3:0]  out_tag;
  logic [2:0]  out_flags;

  int n_checks = 0;
  int n_errors = 0;

  fp_mult_pipe #(.EXP_W(5), .FRAC_W(10), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rnd    (in_rnd),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic rnd, input logic [3:0] tag,
                        input logic [15:0] ep, input logic [2:0] ef);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_rnd    = rnd;
    in_tag    = tag;
    #1 check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_lat2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_p"}, 32'(out_p), 32'(ep));
    check({name, "_flags"}, 32'(out_flags), 32'(ef));
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
  endtask

  logic [15:0] exp_p [8];
  logic [3:0]  exp_t [8];
  logic [15:0] held_p;
  logic [3:0]  held_t;
  logic [2:0]  held_f;
  logic        held;
  int          sent, got;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_rnd    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);

    run_op("one",     16'h3C00, 16'h3C00, 1'b0, 4'h1, 16'h3C00, 3'b000);
    run_op("mul",     16'h4000, 16'h4200, 1'b0, 4'h2, 16'h4600, 3'b000);
    run_op("rne_tie", 16'h3C01, 16'h3E00, 1'b0, 4'h3, 16'h3E02, 3'b001);
    run_op("rtz_tie", 16'h3C01, 16'h3E00, 1'b1, 4'h4, 16'h3E01, 3'b001);
`ifdef FPMUL_SPECIAL_EN
    run_op("ovf_rne", 16'h7BFF, 16'h7BFF, 1'b0, 4'h5, 16'h7C00, 3'b101);
    run_op("ovf_rtz", 16'h7BFF, 16'h7BFF, 1'b1, 4'h6, 16'h7BFF, 3'b101);
    run_op("inf_x_0", 16'h7C00, 16'h0000, 1'b0, 4'h7, 16'h7E00, 3'b000);
    run_op("ninf_x2", 16'hFC00, 16'h4000, 1'b0, 4'h8, 16'hFC00, 3'b000);
    run_op("nan_x1",  16'h7E01, 16'h3C00, 1'b0, 4'h9, 16'h7E00, 3'b000);
`else
    run_op("ovf",     16'h7BFF, 16'h7BFF, 1'b0, 4'h5, 16'h7BFF, 3'b101);
`endif
    run_op("udf",     16'h8400, 16'h0400, 1'b0, 4'hA, 16'h8000, 3'b011);

    // Back-to-back stream of exact products (x * 1.0) under toggling out_ready.
    for (int i = 0; i < 8; i++) begin
      exp_p[i] = 16'h4000 + 16'(i * 16'h0111);
      exp_t[i] = 4'(i) ^ 4'hA;
    end
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_p = '0;
    held_t = '0;
    held_f = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      if (held) begin
        check("stall_p", 32'(out_p), 32'(held_p));
        check("stall_tag", 32'(out_tag), 32'(held_t));
        check("stall_flags", 32'(out_flags), 32'(held_f));
      end
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 8);
      in_a      = (sent < 8) ? exp_p[sent] : 16'h0;
      in_b      = 16'h3C00;
      in_rnd    = 1'b0;
      in_tag    = (sent < 8) ? exp_t[sent] : 4'h0;
      #1;
      if (!in_ready) begin
        check("in_ready_low_out_ready", 32'(out_ready), 32'd0);
        check("in_ready_low_out_valid", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        check("stream_p", 32'(out_p), 32'(exp_p[got]));
        check("stream_tag", 32'(out_tag), 32'(exp_t[got]));
        check("stream_flags", 32'(out_flags), 32'd0);
        got++;
      end
      held   = out_valid && !out_ready;
      held_p = out_p;
      held_t = out_tag;
      held_f = out_flags;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_got", 32'(got), 32'd8);

    // Fill the pipe with three ops, then reset while they are in flight.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 16'h4000;
      in_b     = 16'h4000;
      in_tag   = 4'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_p", 32'(out_p), 32'd0);
    check("midrst_out_tag", 32'(out_tag), 32'd0);
    check("midrst_out_flags", 32'(out_flags), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h4200, 16'h4200, 1'b0, 4'hC, 16'h4880, 3'b000);
    @(negedge clk);
    check("post_rst_drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
